// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Pure declarations: no logic, no timing.
package pipeline_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID source that matches a load's destination in EX.
// Purely combinational, zero latency; no flow control.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_is_load_i,
    output logic                 hazard_o
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_rs1_used_i && (id_rs1_i == ex_rd_i);
        rs2_match = id_rs2_used_i && (id_rs2_i == ex_rd_i);
        // x0 is hardwired to zero, so a load targeting it never produces data to wait for
        hazard_o  = ex_is_load_i && (ex_rd_i != '0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush/redirect controller with stall and flush counters.
// Control outputs are combinational from state and inputs; counters update one cycle later.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_is_load_i,
    input  logic                 ex_redirect_i,
    input  logic                 mem_busy_i,
    output logic                 if_stall_o,
    output logic                 id_stall_o,
    output logic                 id_flush_o,
    output logic                 ex_flush_o,
    output logic                 mem_stall_o,
    output logic                 pc_sel_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    ctrl_state_t      state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_rd_i       (ex_rd_i),
        .ex_is_load_i  (ex_is_load_i),
        .hazard_o      (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            pend_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            RUN: begin
                if (mem_busy_i) begin
                    state_d = MEM_WAIT;
                    pend_d  = ex_redirect_i;
                end
            end
            MEM_WAIT: begin
                if (mem_busy_i) begin
                    pend_d = pend_q | ex_redirect_i;
                end else if (pend_q) begin
                    state_d = REDIRECT;
                end else begin
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                state_d = RUN;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = RUN;
                pend_d  = 1'b0;
            end
        endcase
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, if_stall_o};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, id_flush_o};
    end

    always_comb begin
        if_stall_o  = 1'b0;
        id_stall_o  = 1'b0;
        id_flush_o  = 1'b0;
        ex_flush_o  = 1'b0;
        mem_stall_o = 1'b0;
        pc_sel_o    = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_busy_i) begin
                        if_stall_o  = 1'b1;
                        id_stall_o  = 1'b1;
                        mem_stall_o = 1'b1;
                        ex_flush_o  = 1'b1;
                    end else if (ex_redirect_i) begin
                        pc_sel_o   = 1'b1;
                        id_flush_o = 1'b1;
                        ex_flush_o = 1'b1;
                    end else if (load_use) begin
                        if_stall_o = 1'b1;
                        id_stall_o = 1'b1;
                        ex_flush_o = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy_i) begin
                        if_stall_o  = 1'b1;
                        id_stall_o  = 1'b1;
                        mem_stall_o = 1'b1;
                        ex_flush_o  = 1'b1;
                    end else if (!pend_q && ex_redirect_i) begin
                        // a redirect first seen on the exit cycle is honoured without a stall
                        pc_sel_o   = 1'b1;
                        id_flush_o = 1'b1;
                        ex_flush_o = 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_sel_o   = 1'b1;
                    id_flush_o = 1'b1;
                    ex_flush_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one task per scenario, inline checks.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic        id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
    logic        ex_is_load_i = 1'b0, ex_redirect_i = 1'b0, mem_busy_i = 1'b0;
    logic        if_stall_o, id_stall_o, id_flush_o, ex_flush_o, mem_stall_o, pc_sel_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;
    logic        w_if_stall, w_id_stall, w_id_flush, w_ex_flush, w_mem_stall, w_pc_sel;
    logic [3:0]  w_stall_cnt, w_flush_cnt;
    logic [5:0]  ctrl;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    // ctrl bit order: {if_stall, id_stall, mem_stall, id_flush, ex_flush, pc_sel}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_BUSY  = 6'b111010;
    localparam logic [5:0] C_LDUSE = 6'b110010;
    localparam logic [5:0] C_REDIR = 6'b000111;

    always #5 clk = ~clk;
    assign ctrl = {if_stall_o, id_stall_o, mem_stall_o, id_flush_o, ex_flush_o, pc_sel_o};

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
        .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
        .if_stall_o(if_stall_o), .id_stall_o(id_stall_o),
        .id_flush_o(id_flush_o), .ex_flush_o(ex_flush_o),
        .mem_stall_o(mem_stall_o), .pc_sel_o(pc_sel_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
        .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
        .if_stall_o(w_if_stall), .id_stall_o(w_id_stall),
        .id_flush_o(w_id_flush), .ex_flush_o(w_ex_flush),
        .mem_stall_o(w_mem_stall), .pc_sel_o(w_pc_sel),
        .stall_cnt_o(w_stall_cnt), .flush_cnt_o(w_flush_cnt)
    );

    // Apply one cycle's inputs at the falling edge, settle, then the caller checks.
    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic ld,
                         input logic redir, input logic busy);
        @(negedge clk);
        id_rs1_i = rs1; id_rs1_used_i = u1;
        id_rs2_i = rs2; id_rs2_used_i = u2;
        ex_rd_i = rd; ex_is_load_i = ld;
        ex_redirect_i = redir; mem_busy_i = busy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {id_rs1_i, id_rs2_i, ex_rd_i} = '0;
        {id_rs1_used_i, id_rs2_used_i, ex_is_load_i, ex_redirect_i, mem_busy_i} = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_busy_i = 1'b1; ex_redirect_i = 1'b1;
        #1;
        chk_cnt++;
        if (ctrl !== C_NONE) $display("FAIL reset_ctrl got %b want %b", ctrl, C_NONE);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (stall_cnt_o !== 32'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt_o);
        else pass_cnt++;
        chk_cnt++;
        if (flush_cnt_o !== 32'd0) $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt_o);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        // EX: ld x5   ID: add x6,x5,x1
        drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (ctrl !== C_LDUSE) $display("FAIL load_use_ctrl got %b want %b", ctrl, C_LDUSE);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (stall_cnt_o !== 32'd1) $display("FAIL load_use_stall_cnt got %0d want 1", stall_cnt_o);
        else pass_cnt++;
        // bubble now in EX: the add proceeds
        drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (ctrl !== C_NONE) $display("FAIL load_use_release got %b want %b", ctrl, C_NONE);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (stall_cnt_o !== 32'd1 || flush_cnt_o !== 32'd0)
            $display("FAIL load_use_cnts got %0d/%0d want 1/0", stall_cnt_o, flush_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_no_hazard();
        do_reset();
        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (ctrl !== C_NONE) $display("FAIL nohaz_x0 got %b want %b", ctrl, C_NONE);
        else pass_cnt++;
        drive(5'd5, 1'b0, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (ctrl !== C_NONE) $display("FAIL nohaz_unused got %b want %b", ctrl, C_NONE);
        else pass_cnt++;
        drive(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (ctrl !== C_NONE) $display("FAIL nohaz_not_load got %b want %b", ctrl, C_NONE);
        else pass_cnt++;
        drive(5'd2, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (ctrl !== C_LDUSE) $display("FAIL haz_rs2 got %b want %b", ctrl, C_LDUSE);
        else pass_cnt++;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_redirect_priority();
        do_reset();
        drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        chk_cnt++;
        if (ctrl !== C_REDIR) $display("FAIL redir_over_lduse got %b want %b", ctrl, C_REDIR);
        else pass_cnt++;
        tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd0)
            $display("FAIL redir_cnts got %0d/%0d want 1/0", flush_cnt_o, stall_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_mem_wait_redirect();
        logic [5:0] exp_seq [0:5];
        exp_seq = '{C_BUSY, C_BUSY, C_BUSY, C_NONE, C_REDIR, C_NONE};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, (i == 0), (i < 3));
            chk_cnt++;
            if (ctrl !== exp_seq[i])
                $display("FAIL memwait_cycle%0d got %b want %b", i, ctrl, exp_seq[i]);
            else pass_cnt++;
            tick();
        end
        chk_cnt++;
        if (stall_cnt_o !== 32'd3 || flush_cnt_o !== 32'd1)
            $display("FAIL memwait_cnts got %0d/%0d want 3/1", stall_cnt_o, flush_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_cnt++;
        if (stall_cnt_o !== 32'd2 || ctrl !== C_BUSY)
            $display("FAIL midwait_pre got cnt %0d ctrl %b want 2 %b", stall_cnt_o, ctrl, C_BUSY);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (ctrl !== C_NONE || stall_cnt_o !== 32'd0)
            $display("FAIL midwait_async_rst got ctrl %b cnt %0d want %b 0", ctrl, stall_cnt_o, C_NONE);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        mem_busy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++;
            if (ctrl !== C_NONE)
                $display("FAIL midwait_no_redirect%0d got %b want %b", i, ctrl, C_NONE);
            else pass_cnt++;
            @(negedge clk);
        end
        chk_cnt++;
        if (flush_cnt_o !== 32'd0) $display("FAIL midwait_flush_cnt got %0d want 0", flush_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (w_stall_cnt !== 4'd1) $display("FAIL wrap_cnt4 got %0d want 1", w_stall_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (stall_cnt_o !== 32'd17) $display("FAIL wrap_cnt32 got %0d want 17", stall_cnt_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect_priority();
        test_mem_wait_redirect();
        test_reset_mid_wait();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
